// File: rtl/fc_mover_mac_nlane_if.sv
// Control, status and BRAM port bundle for the n-lane fully-connected MAC mover.
// master is the mover side; slave is the control block plus the BRAMs.
interface fc_mover_mac_nlane_if #(
   parameter int unsigned NUM_CORE = 4,
   parameter int unsigned IN_DW    = 8,
   parameter int unsigned ACC_DW   = 32,
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned CNT_BIT  = 16
) ();
   localparam int unsigned LANE_W = NUM_CORE * IN_DW;
   localparam int unsigned RES_W  = NUM_CORE * ACC_DW;

   logic               i_run;
   logic [CNT_BIT-1:0] i_num_cnt;
   logic [AWIDTH-1:0]  i_out_base;
   logic               i_relu_en;
   logic               o_idle;
   logic               o_busy;
   logic               o_done;
   logic [AWIDTH-1:0]  addr_n;
   logic               ce_n;
   logic [LANE_W-1:0]  q_n;
   logic [AWIDTH-1:0]  addr_w;
   logic               ce_w;
   logic [LANE_W-1:0]  q_w;
   logic [AWIDTH-1:0]  addr_b;
   logic               ce_b;
   logic [LANE_W-1:0]  q_b;
   logic [AWIDTH-1:0]  addr_o;
   logic               ce_o;
   logic               we_o;
   logic [ACC_DW-1:0]  d_o;
   logic [RES_W-1:0]   o_result;
   logic               o_result_valid;

   modport master (
      input  i_run, i_num_cnt, i_out_base, i_relu_en, q_n, q_w, q_b,
      output o_idle, o_busy, o_done, addr_n, ce_n, addr_w, ce_w, addr_b, ce_b,
             addr_o, ce_o, we_o, d_o, o_result, o_result_valid
   );

   modport slave (
      output i_run, i_num_cnt, i_out_base, i_relu_en, q_n, q_w, q_b,
      input  o_idle, o_busy, o_done, addr_n, ce_n, addr_w, ce_w, addr_b, ce_b,
             addr_o, ce_o, we_o, d_o, o_result, o_result_valid
   );
endinterface

// File: rtl/fc_mover_mac_nlane.sv
// Streams NUM_CORE packed signed lanes from node/weight BRAMs, MACs them onto a bias
// seed per lane, applies optional ReLU and writes the results to the output BRAM.
module fc_mover_mac_nlane #(
   parameter int unsigned NUM_CORE = 4,
   parameter int unsigned IN_DW    = 8,
   parameter int unsigned ACC_DW   = 32,
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned CNT_BIT  = 16
) (
   input logic clk,
   input logic reset,
   fc_mover_mac_nlane_if.master bus
);
   localparam int unsigned PROD_W = 2 * IN_DW;

   typedef enum logic [2:0] {
      S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_BIT-1:0] cnt_q, cnt_d;
   logic [CNT_BIT-1:0] num_q, num_d;
   logic [AWIDTH-1:0]  base_q, base_d;
   logic               relu_q, relu_d;
   logic               acc_clr;
   logic               res_ld;
   logic               mac_first;
   logic               mac_add;
   logic [ACC_DW-1:0]  r_c [NUM_CORE];

   // State and captured-job registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         base_q  <= '0;
         relu_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         base_q  <= base_d;
         relu_q  <= relu_d;
      end
   end

   // Next-state, counter and job capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      base_d  = base_q;
      relu_d  = relu_q;
      acc_clr = 1'b0;
      res_ld  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_run) begin
               num_d   = bus.i_num_cnt;
               base_d  = bus.i_out_base;
               relu_d  = bus.i_relu_en;
               cnt_d   = '0;
               acc_clr = 1'b1;
               if (bus.i_num_cnt == '0) begin
                  state_d = S_DONE;
                  res_ld  = 1'b1;
               end else begin
                  state_d = S_BIAS;
               end
            end
         end
         S_BIAS:  state_d = S_MAC;
         S_MAC: begin
            if (cnt_q == num_q - CNT_BIT'(1)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_BIT'(1);
            end
         end
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: begin
            if (cnt_q == CNT_BIT'(NUM_CORE - 1)) begin
               cnt_d   = '0;
               res_ld  = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_BIT'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bias arrives in the first MAC cycle; each product lands one cycle after its read
   assign mac_first = (state_q == S_MAC) && (cnt_q == '0);
   assign mac_add   = ((state_q == S_MAC) && (cnt_q != '0)) || (state_q == S_DRAIN);

   for (genvar k = 0; k < NUM_CORE; k++) begin : g_lane
      localparam int unsigned IN_LO  = (NUM_CORE - 1 - k) * IN_DW;
      localparam int unsigned RES_LO = (NUM_CORE - 1 - k) * ACC_DW;

      logic signed [IN_DW-1:0]  n_s;
      logic signed [IN_DW-1:0]  w_s;
      logic signed [IN_DW-1:0]  b_s;
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_DW-1:0] acc_q;
      logic [ACC_DW-1:0]        res_q;

      assign n_s  = bus.q_n[IN_LO +: IN_DW];
      assign w_s  = bus.q_w[IN_LO +: IN_DW];
      assign b_s  = bus.q_b[IN_LO +: IN_DW];
      assign prod = n_s * w_s;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            acc_q <= '0;
         end else if (acc_clr) begin
            acc_q <= '0;
         end else if (mac_first) begin
            acc_q <= ACC_DW'(b_s);
         end else if (mac_add) begin
            acc_q <= acc_q + ACC_DW'(prod);
         end
      end

      assign r_c[k] = (relu_q && acc_q[ACC_DW-1]) ? '0 : acc_q;

      // A zero-length job reports zeros rather than a stale accumulator
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            res_q <= '0;
         end else if (res_ld) begin
            res_q <= acc_clr ? '0 : r_c[k];
         end
      end

      assign bus.o_result[RES_LO +: ACC_DW] = res_q;
   end

   // Write-back data select by lane index
   always_comb begin
      bus.d_o = '0;
      if (state_q == S_WRITE) begin
         for (int k = 0; k < NUM_CORE; k++) begin
            if (cnt_q == CNT_BIT'(k)) bus.d_o = r_c[k];
         end
      end
   end

   assign bus.o_idle         = (state_q == S_IDLE);
   assign bus.o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.o_done         = (state_q == S_DONE);
   assign bus.o_result_valid = (state_q == S_DONE);

   assign bus.ce_n   = (state_q == S_MAC);
   assign bus.ce_w   = (state_q == S_MAC);
   assign bus.addr_n = (state_q == S_MAC) ? AWIDTH'(cnt_q) : '0;
   assign bus.addr_w = (state_q == S_MAC) ? AWIDTH'(cnt_q) : '0;
   assign bus.ce_b   = (state_q == S_BIAS);
   assign bus.addr_b = '0;
   assign bus.ce_o   = (state_q == S_WRITE);
   assign bus.we_o   = (state_q == S_WRITE);
   assign bus.addr_o = (state_q == S_WRITE) ? base_q + AWIDTH'(cnt_q) : '0;

endmodule

// File: tb/tb_fc_mover_mac_nlane.sv
// Directed bench for fc_mover_mac_nlane with behavioural node/weight/bias/result BRAMs.
module tb_fc_mover_mac_nlane;
   localparam int unsigned NUM_CORE = 4;
   localparam int unsigned IN_DW    = 8;
   localparam int unsigned ACC_DW   = 32;
   localparam int unsigned AWIDTH   = 12;
   localparam int unsigned CNT_BIT  = 16;

   logic clk;
   logic reset;

   fc_mover_mac_nlane_if #(
      .NUM_CORE(NUM_CORE), .IN_DW(IN_DW), .ACC_DW(ACC_DW),
      .AWIDTH(AWIDTH), .CNT_BIT(CNT_BIT)
   ) bus ();

   fc_mover_mac_nlane #(
      .NUM_CORE(NUM_CORE), .IN_DW(IN_DW), .ACC_DW(ACC_DW),
      .AWIDTH(AWIDTH), .CNT_BIT(CNT_BIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] node_mem [4096];
   logic [31:0] wgt_mem  [4096];
   logic [31:0] bias_word;
   logic [31:0] out_mem  [4096];
   int n_ce_n, n_ce_w, n_ce_b, n_we, bad_addr_b;
   int tests, failed;

   // BRAM models: one-cycle read latency, write on the edge
   always @(posedge clk) begin
      if (bus.ce_n) bus.q_n <= node_mem[bus.addr_n];
      if (bus.ce_w) bus.q_w <= wgt_mem[bus.addr_w];
      if (bus.ce_b) bus.q_b <= bias_word;
      if (bus.ce_o && bus.we_o) out_mem[bus.addr_o] <= bus.d_o;
      if (bus.ce_n) n_ce_n++;
      if (bus.ce_w) n_ce_w++;
      if (bus.ce_b) n_ce_b++;
      if (bus.we_o) n_we++;
      if (bus.ce_b && bus.addr_b != '0) bad_addr_b++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int n, input logic [31:0] nv, input logic [31:0] wv, input logic [31:0] bv);
      for (int i = 0; i < n; i++) begin
         node_mem[i] = nv;
         wgt_mem[i]  = wv;
      end
      bias_word = bv;
   endtask

   task automatic clear_counts();
      n_ce_n = 0; n_ce_w = 0; n_ce_b = 0; n_we = 0;
   endtask

   task automatic wait_done(inout int cyc);
      while (!bus.o_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 128'(bus.o_done), 128'(1));
   endtask

   task automatic run_job(input int n, input logic [11:0] base, input logic relu, output int cyc);
      bus.i_num_cnt  = CNT_BIT'(n);
      bus.i_out_base = base;
      bus.i_relu_en  = relu;
      clear_counts();
      @(negedge clk) bus.i_run = 1'b1;
      @(negedge clk) bus.i_run = 1'b0;
      cyc = 1;
      wait_done(cyc);
   endtask

   task automatic seed_out(input logic [11:0] base);
      for (int k = 0; k < NUM_CORE; k++) out_mem[12'(base + 12'(k))] = 32'hDEAD_BEEF;
   endtask

   int          cyc;
   logic [11:0] a;

   initial begin
      tests = 0; failed = 0; bad_addr_b = 0;
      clear_counts();
      bus.i_run = 1'b0; bus.i_num_cnt = '0; bus.i_out_base = '0; bus.i_relu_en = 1'b0;
      bus.q_n = '0; bus.q_w = '0; bus.q_b = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_idle",   128'(bus.o_idle), 128'(1));
      check("rst_busy",   128'(bus.o_busy), 128'(0));
      check("rst_done",   128'(bus.o_done), 128'(0));
      check("rst_result", 128'(bus.o_result), 128'(0));
      reset = 1'b0;
      @(negedge clk);

      // Basic lane mapping
      fill(1, 32'h0102_0304, 32'h0101_0101, 32'h0);
      seed_out(12'h010);
      run_job(1, 12'h010, 1'b0, cyc);
      check("s1_latency", 128'(cyc), 128'(8));
      check("s1_valid",   128'(bus.o_result_valid), 128'(1));
      check("s1_result",  128'(bus.o_result), {32'h0, 32'd1, 32'd2, 32'd3, 32'd4});
      check("s1_mem10",   128'(out_mem[12'h010]), 128'(1));
      check("s1_mem13",   128'(out_mem[12'h013]), 128'(4));
      check("s1_ce_n",    128'(n_ce_n), 128'(1));
      @(negedge clk);
      check("s1_done_pulse", 128'(bus.o_done), 128'(0));
      check("s1_hold",    128'(bus.o_result), {32'h0, 32'd1, 32'd2, 32'd3, 32'd4});

      // Negative products onto bias, with and without ReLU
      fill(4, 32'hFFFF_FFFF, 32'h0202_0202, 32'h0505_0505);
      run_job(4, 12'h020, 1'b0, cyc);
      check("s2_latency", 128'(cyc), 128'(11));
      check("s2_result",  128'(bus.o_result), {32'h0, {4{32'hFFFF_FFFD}}});
      check("s2_mem21",   128'(out_mem[12'h021]), 128'(32'hFFFF_FFFD));
      run_job(4, 12'h020, 1'b1, cyc);
      check("s2_relu",    128'(bus.o_result), 128'(0));
      check("s2_relu_mem",128'(out_mem[12'h023]), 128'(0));

      // Long run at the most negative element value, then address wrap
      fill(256, 32'h8080_8080, 32'h8080_8080, 32'h0);
      run_job(256, 12'h030, 1'b0, cyc);
      check("s3_latency", 128'(cyc), 128'(263));
      check("s3_result",  128'(bus.o_result), {32'h0, {4{32'h0040_0000}}});
      check("s3_ce_w",    128'(n_ce_w), 128'(256));
      seed_out(12'hFFE);
      run_job(256, 12'hFFE, 1'b0, cyc);
      check("s3_wrap_ffe", 128'(out_mem[12'hFFE]), 128'(32'h0040_0000));
      check("s3_wrap_fff", 128'(out_mem[12'hFFF]), 128'(32'h0040_0000));
      check("s3_wrap_000", 128'(out_mem[12'h000]), 128'(32'h0040_0000));
      check("s3_wrap_001", 128'(out_mem[12'h001]), 128'(32'h0040_0000));
      check("s3_we",       128'(n_we), 128'(4));

      // Zero-length job: no BRAM traffic, immediate done, zero result
      fill(1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h1111_1111);
      run_job(0, 12'h040, 1'b0, cyc);
      check("s4_latency", 128'(cyc), 128'(1));
      check("s4_result",  128'(bus.o_result), 128'(0));
      check("s4_traffic", 128'(n_ce_n + n_ce_w + n_ce_b + n_we), 128'(0));

      // Asynchronous reset mid-MAC
      fill(8, 32'h0303_0303, 32'h0303_0303, 32'h0);
      run_job(1, 12'h050, 1'b0, cyc);
      check("s5_pre",     128'(bus.o_result), {32'h0, {4{32'd9}}});
      @(negedge clk);
      bus.i_num_cnt = 16'd8;
      @(negedge clk) bus.i_run = 1'b1;
      @(negedge clk) bus.i_run = 1'b0;
      cyc = 1;
      while (!(bus.ce_n && bus.addr_n == 12'd3) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("s5_reached_cnt3", 128'(bus.addr_n), 128'(3));
      reset = 1'b1;
      #1;
      check("s5_idle",   128'(bus.o_idle), 128'(1));
      check("s5_outs",   128'({bus.o_busy, bus.o_done, bus.ce_n, bus.ce_w, bus.ce_b,
                               bus.ce_o, bus.we_o, bus.o_result_valid}), 128'(0));
      check("s5_addr",   128'({bus.addr_n, bus.addr_o, bus.d_o}), 128'(0));
      check("s5_result", 128'(bus.o_result), 128'(0));
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      fill(1, 32'h0102_0304, 32'h0101_0101, 32'h0);
      run_job(1, 12'h010, 1'b0, cyc);
      check("s5_rerun",  128'(bus.o_result), {32'h0, 32'd1, 32'd2, 32'd3, 32'd4});

      // Stray i_run during MAC and DONE ignored; one cycle after DONE restarts
      fill(1, 32'h0102_0304, 32'h0202_0202, 32'h0);
      bus.i_num_cnt = 16'd1; bus.i_out_base = 12'h060; bus.i_relu_en = 1'b0;
      clear_counts();
      @(negedge clk) bus.i_run = 1'b1;
      @(negedge clk) bus.i_run = 1'b0;
      @(negedge clk) bus.i_run = 1'b1;
      @(negedge clk) bus.i_run = 1'b0;
      cyc = 3;
      wait_done(cyc);
      check("s6_latency", 128'(cyc), 128'(8));
      check("s6_result",  128'(bus.o_result), {32'h0, 32'd2, 32'd4, 32'd6, 32'd8});
      bus.i_run = 1'b1;
      @(negedge clk);
      check("s6_idle_after_done", 128'(bus.o_idle), 128'(1));
      fill(1, 32'h0101_0101, 32'h0505_0505, 32'h0);
      clear_counts();
      @(negedge clk) bus.i_run = 1'b0;
      cyc = 1;
      wait_done(cyc);
      check("s6_second_latency", 128'(cyc), 128'(8));
      check("s6_second_result",  128'(bus.o_result), {32'h0, {4{32'd5}}});
      check("s6_second_ce_b",    128'(n_ce_b), 128'(1));

      for (int k = 0; k < NUM_CORE; k++) begin
         a = 12'h060 + 12'(k);
         check("s6_mem", 128'(out_mem[a]), 128'(5));
      end
      check("addr_b_zero", 128'(bad_addr_b), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
